// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game-flow controller and the mouse/menu decode, move checker and stage/state registers.
// master = controller side, slave = surrounding datapath.
interface game_flow_ctrl_if #(
  parameter int CELLS   = 64,
  parameter int STAGE_W = 2,
  parameter int UNDO_W  = 4,
  parameter int CNT_W   = 10
);
  logic               restart;
  logic               left;
  logic               retry;
  logic               retract;
  logic               game_area;
  logic               move_result;
  logic [CELLS-1:0]   box;
  logic [CELLS-1:0]   destination;
  logic [STAGE_W-1:0] stage;
  logic               game_state_en;
  logic [1:0]         sel;
  logic               stage_up;
  logic               win;
  logic [CNT_W-1:0]   move_count;
  logic [UNDO_W-1:0]  undo_avail;
  logic [3:0]         fsm_state;

  modport master (
    input  restart, left, retry, retract, game_area, move_result, box, destination, stage,
    output game_state_en, sel, stage_up, win, move_count, undo_avail, fsm_state
  );

  modport slave (
    output restart, left, retry, retract, game_area, move_result, box, destination, stage,
    input  game_state_en, sel, stage_up, win, move_count, undo_avail, fsm_state
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Sokoban game-flow FSM (level load, move, retract, stage advance); optional step limit / LOSE state via GAME_FLOW_STEP_LIMIT_EN.
// Latency: left click to game_state_en 2 cycles; no backpressure, inputs are levels sampled every cycle.
module game_flow_ctrl #(
  parameter int CELLS      = 64,
  parameter int NUM_STAGES = 4,
  parameter int STAGE_W    = 2,
  parameter int UNDO_DEPTH = 8,
  parameter int UNDO_W     = 4,
  parameter int CNT_W      = 10
`ifdef GAME_FLOW_STEP_LIMIT_EN
  ,
  parameter int MAX_STEPS  = 500
`endif
) (
  input  logic             clk,
  input  logic             reset,
  game_flow_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_INIT    = 4'd1,
    S_WAIT    = 4'd2,
    S_PAUSE   = 4'd3,
    S_OVER    = 4'd4,
    S_NEXT    = 4'd5,
    S_INTERIM = 4'd6,
    S_RETRACT = 4'd7,
    S_MOVE    = 4'd8,
    S_LOSE    = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [UNDO_W-1:0]  UNDO_MAX   = UNDO_W'(UNDO_DEPTH);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  state_t             state_q, state_d;
  logic               left_q;
  logic               en_q, en_d;
  logic [1:0]         sel_q, sel_d;
  logic               stage_up_q, stage_up_d;
  logic               win_q, win_d;
  logic [CNT_W-1:0]   move_count_q, move_count_d;
  logic [UNDO_W-1:0]  undo_avail_q, undo_avail_d;

  logic [CELLS-1:0]   box_w;
  logic [CELLS-1:0]   dest_w;
  logic               click;
  logic               solved;
  logic               last_stage;
  logic               state_legal;

  assign box_w      = bus.box;
  assign dest_w     = bus.destination;
  assign click      = bus.left & ~left_q;
  assign solved     = (box_w == dest_w);
  assign last_stage = (bus.stage == LAST_STAGE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RESET;
      left_q       <= 1'b0;
      en_q         <= 1'b0;
      sel_q        <= 2'd0;
      stage_up_q   <= 1'b0;
      win_q        <= 1'b0;
      move_count_q <= '0;
      undo_avail_q <= '0;
    end else begin
      state_q      <= state_d;
      left_q       <= bus.left;
      en_q         <= en_d;
      sel_q        <= sel_d;
      stage_up_q   <= stage_up_d;
      win_q        <= win_d;
      move_count_q <= move_count_d;
      undo_avail_q <= undo_avail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.restart) begin
      state_d = S_RESET;
    end else begin
      case (state_q)
        S_RESET:   state_d = S_INIT;
        S_INIT:    state_d = S_WAIT;
        S_WAIT: begin
          // Solved wins over both the step limit and a pending click.
          if (solved)
            state_d = last_stage ? S_OVER : S_PAUSE;
`ifdef GAME_FLOW_STEP_LIMIT_EN
          else if (move_count_q == CNT_W'(MAX_STEPS))
            state_d = S_LOSE;
`endif
          else if (click)
            state_d = S_INTERIM;
        end
        S_INTERIM: begin
          if (bus.retry)
            state_d = S_INIT;
          else if (bus.retract)
            state_d = (undo_avail_q != '0) ? S_RETRACT : S_WAIT;
          else if (bus.game_area && bus.move_result)
            state_d = S_MOVE;
          else
            state_d = S_WAIT;
        end
        S_MOVE:    state_d = S_WAIT;
        S_RETRACT: state_d = S_WAIT;
        S_PAUSE:   if (click) state_d = S_NEXT;
        S_NEXT:    state_d = S_INIT;
        S_OVER:    state_d = S_OVER;
`ifdef GAME_FLOW_STEP_LIMIT_EN
        S_LOSE:    if (click) state_d = S_INIT;
`endif
        default:   state_d = S_RESET;
      endcase
    end
  end

  always_comb begin
    state_legal = 1'b1;
    case (state_q)
      S_RESET, S_INIT, S_WAIT, S_PAUSE, S_OVER,
      S_NEXT, S_INTERIM, S_RETRACT, S_MOVE: state_legal = 1'b1;
`ifdef GAME_FLOW_STEP_LIMIT_EN
      S_LOSE:  state_legal = 1'b1;
`endif
      default: state_legal = 1'b0;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with fsm_state.
  always_comb begin
    en_d         = 1'b0;
    sel_d        = 2'd0;
    stage_up_d   = 1'b0;
    win_d        = 1'b0;
    move_count_d = move_count_q;
    undo_avail_d = undo_avail_q;
    if (state_legal) begin
      case (state_d)
        S_RESET: en_d = 1'b1;
        S_INIT: begin
          en_d         = 1'b1;
          move_count_d = '0;
          undo_avail_d = '0;
        end
        S_MOVE: begin
          en_d  = 1'b1;
          sel_d = 2'd1;
          if (move_count_q != CNT_MAX)
            move_count_d = move_count_q + CNT_W'(1);
          if (undo_avail_q < UNDO_MAX)
            undo_avail_d = undo_avail_q + UNDO_W'(1);
        end
        S_RETRACT: begin
          en_d  = 1'b1;
          sel_d = 2'd3;
          if (move_count_q != '0)
            move_count_d = move_count_q - CNT_W'(1);
          if (undo_avail_q != '0)
            undo_avail_d = undo_avail_q - UNDO_W'(1);
        end
        S_NEXT:  stage_up_d = 1'b1;
        S_OVER:  win_d      = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.game_state_en = en_q;
  assign bus.sel           = sel_q;
  assign bus.stage_up      = stage_up_q;
  assign bus.win           = win_q;
  assign bus.move_count    = move_count_q;
  assign bus.undo_avail    = undo_avail_q;
  assign bus.fsm_state     = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed sequence plus random click actions against a rule-level model.
module tb_game_flow_ctrl;
  localparam int CELLS      = 64;
  localparam int NUM_STAGES = 4;
  localparam int STAGE_W    = 2;
  localparam int UNDO_DEPTH = 8;
  localparam int UNDO_W     = 4;
  localparam int CNT_W      = 10;
  localparam int MAX_CNT    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_flow_ctrl_if #(.CELLS(CELLS), .STAGE_W(STAGE_W), .UNDO_W(UNDO_W), .CNT_W(CNT_W)) bus ();

  game_flow_ctrl #(
    .CELLS(CELLS), .NUM_STAGES(NUM_STAGES), .STAGE_W(STAGE_W),
    .UNDO_DEPTH(UNDO_DEPTH), .UNDO_W(UNDO_W), .CNT_W(CNT_W)
`ifdef GAME_FLOW_STEP_LIMIT_EN
    , .MAX_STEPS(5)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int exp_mc    = 0;
  int exp_undo  = 0;
  logic [CELLS-1:0] pattern;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int st, input int en, input int sl);
    chk({tag, ".state"}, bus.fsm_state, st);
    chk({tag, ".en"}, bus.game_state_en, en);
    chk({tag, ".sel"}, bus.sel, sl);
    chk({tag, ".move_count"}, bus.move_count, exp_mc);
    chk({tag, ".undo_avail"}, bus.undo_avail, exp_undo);
  endtask

  // One click from WAIT; expected result derived from the game rules.
  task automatic action(input bit ga, input bit mr, input bit rty, input bit rtr);
    int st;
    int en;
    int sl;
    bus.left = 1'b1; bus.game_area = ga; bus.move_result = mr;
    bus.retry = rty; bus.retract = rtr;
    tick();
    check_out("interim", 6, 0, 0);
    bus.left = 1'b0;
    if (rty) begin
      st = 1; en = 1; sl = 0; exp_mc = 0; exp_undo = 0;
    end else if (rtr) begin
      if (exp_undo > 0) begin
        st = 7; en = 1; sl = 3;
        exp_undo = exp_undo - 1;
        exp_mc   = (exp_mc > 0) ? exp_mc - 1 : 0;
      end else begin
        st = 2; en = 0; sl = 0;
      end
    end else if (ga && mr) begin
      st = 8; en = 1; sl = 1;
      exp_mc   = (exp_mc < MAX_CNT) ? exp_mc + 1 : MAX_CNT;
      exp_undo = (exp_undo < UNDO_DEPTH) ? exp_undo + 1 : UNDO_DEPTH;
    end else begin
      st = 2; en = 0; sl = 0;
    end
    tick();
    check_out("commit", st, en, sl);
    bus.game_area = 1'b0; bus.move_result = 1'b0; bus.retry = 1'b0; bus.retract = 1'b0;
    if (st != 2) begin
      tick();
      check_out("settle", 2, 0, 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.restart = 1'b0; bus.left = 1'b0; bus.retry = 1'b0; bus.retract = 1'b0;
    bus.game_area = 1'b0; bus.move_result = 1'b0; bus.stage = '0;
    pattern = {$urandom, $urandom};
    bus.box = pattern; bus.destination = ~pattern;
    tick(); tick();
    check_out("reset", 0, 0, 0);
    chk("reset.win", bus.win, 0);
    chk("reset.stage_up", bus.stage_up, 0);

    reset = 1'b1;
    tick();
    check_out("init", 1, 1, 0);
    tick();
    check_out("wait", 2, 0, 0);

`ifdef GAME_FLOW_STEP_LIMIT_EN
    for (int i = 0; i < 5; i++) action(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("lose", 9, 0, 0);
    bus.left = 1'b1;
    tick();
    exp_mc = 0; exp_undo = 0;
    check_out("lose.reload", 1, 1, 0);
    bus.left = 1'b0;
    tick();
    check_out("lose.wait", 2, 0, 0);
`else
    for (int i = 0; i < 3; i++) action(1'b1, 1'b1, 1'b0, 1'b0);
    chk("three.move_count", bus.move_count, 3);
    chk("three.undo_avail", bus.undo_avail, 3);

    // Held button gives only one click.
    bus.left = 1'b1;
    tick(); check_out("hold.interim", 6, 0, 0);
    tick(); check_out("hold.wait", 2, 0, 0);
    tick(); check_out("hold.noclick", 2, 0, 0);
    bus.left = 1'b0;
    tick();

    action(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) action(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) action(1'b0, 1'b0, 1'b0, 1'b1);
    chk("undo.final_undo", bus.undo_avail, 0);
    chk("undo.final_count", bus.move_count, 2);

    for (int i = 0; i < 40; i++)
      action(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));

    // Restart while in MOVE.
    bus.left = 1'b1; bus.game_area = 1'b1; bus.move_result = 1'b1;
    tick();
    bus.left = 1'b0;
    tick();
    chk("rst_mv.state", bus.fsm_state, 8);
    bus.restart = 1'b1; bus.game_area = 1'b0; bus.move_result = 1'b0;
    tick();
    chk("restart.state", bus.fsm_state, 0);
    chk("restart.en", bus.game_state_en, 1);
    chk("restart.sel", bus.sel, 0);
    bus.restart = 1'b0;
    exp_mc = 0; exp_undo = 0;
    tick(); check_out("restart.init", 1, 1, 0);
    tick(); check_out("restart.wait", 2, 0, 0);

    // Stage clear at a non-final stage.
    bus.stage = 2'd1; bus.destination = pattern;
    tick(); check_out("pause", 3, 0, 0);
    tick(); check_out("pause.hold", 3, 0, 0);
    bus.left = 1'b1;
    tick();
    chk("next.state", bus.fsm_state, 5);
    chk("next.stage_up", bus.stage_up, 1);
    bus.left = 1'b0;
    tick();
    chk("next.init", bus.fsm_state, 1);
    chk("next.stage_up_off", bus.stage_up, 0);
    chk("next.en", bus.game_state_en, 1);
    bus.destination = ~pattern;
    tick(); check_out("next.wait", 2, 0, 0);

    // Final stage cleared: OVER absorbs clicks.
    bus.stage = 2'd3; bus.destination = pattern;
    tick();
    chk("over.state", bus.fsm_state, 4);
    chk("over.win", bus.win, 1);
    bus.left = 1'b1; bus.destination = ~pattern;
    tick();
    bus.left = 1'b0;
    tick(); tick();
    chk("over.stay", bus.fsm_state, 4);
    chk("over.win_hold", bus.win, 1);

    bus.restart = 1'b1; bus.stage = 2'd0;
    tick();
    bus.restart = 1'b0;
    tick(); tick();
    check_out("back.wait", 2, 0, 0);
    chk("back.win", bus.win, 0);

    // Async reset while in INTERIM.
    action(1'b1, 1'b1, 1'b0, 1'b0);
    bus.left = 1'b1; bus.game_area = 1'b1; bus.move_result = 1'b1;
    tick();
    check_out("async.interim", 6, 0, 0);
    #2 reset = 1'b0;
    #1;
    exp_mc = 0; exp_undo = 0;
    check_out("async", 0, 0, 0);
    chk("async.win", bus.win, 0);
    bus.left = 1'b0; bus.game_area = 1'b0; bus.move_result = 1'b0;
    tick();
    reset = 1'b1;
    tick(); check_out("async.init", 1, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
